// File: rtl/ysyx_22050550_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050550_lsu
// Purpose  : Load/store stage between EXU and WBU. Issues one data-memory
//            request per memory packet, formats load data, aborts misaligned
//            or faulted accesses and discards in-flight work on a flush.
// Config   : YSYX_22050550_LSU_MISALIGN_TRAP_EN - when defined, accesses not
//            aligned to their size are aborted without a memory request;
//            otherwise the byte offset is aligned down to the access size.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050550_lsu (
    input  logic        clock,
    input  logic        reset,
    // EXU packet
    input  logic        io_EXLS_valid,
    output logic        io_EXLS_ready,
    input  logic [63:0] io_EXLS_pc,
    input  logic [31:0] io_EXLS_inst,
    input  logic [63:0] io_EXLS_NextPc,
    input  logic [63:0] io_EXLS_alures,
    input  logic [63:0] io_EXLS_rs2,
    input  logic        io_EXLS_readflag,
    input  logic        io_EXLS_writeflag,
    input  logic [2:0]  io_EXLS_func3,
    input  logic [4:0]  io_EXLS_waddr,
    input  logic        io_EXLS_wen,
    input  logic        io_EXLS_csrflag,
    input  logic        io_EXLS_ecallflag,
    input  logic        io_EXLS_mretflag,
    input  logic        io_EXLS_ebreak,
    input  logic        io_ls_flush,
    // Data memory
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    input  logic        mem_resp_err,
    // WBU packet
    output logic        io_LSWB_valid,
    input  logic        io_ReadyWB_ready,
    output logic [63:0] io_LSWB_pc,
    output logic [31:0] io_LSWB_inst,
    output logic [63:0] io_LSWB_NextPc,
    output logic [63:0] io_LSWB_alures,
    output logic [63:0] io_LSWB_lsures,
    output logic [4:0]  io_LSWB_waddr,
    output logic        io_LSWB_wen,
    output logic [2:0]  io_LSWB_func3,
    output logic        io_LSWB_readflag,
    output logic        io_LSWB_csrflag,
    output logic        io_LSWB_ecallflag,
    output logic        io_LSWB_mretflag,
    output logic        io_LSWB_ebreak,
    output logic        io_LSWB_abort
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Latched memory packet
    logic [63:0] r_pkt_pc;
    logic [31:0] r_pkt_inst;
    logic [63:0] r_pkt_nextpc;
    logic [63:0] r_pkt_alures;
    logic        r_pkt_readflag;
    logic        r_pkt_writeflag;
    logic [2:0]  r_pkt_func3;
    logic [2:0]  r_pkt_off;
    logic [4:0]  r_pkt_waddr;
    logic        r_pkt_wen;
    logic        r_pkt_csrflag;
    logic        r_pkt_ecallflag;
    logic        r_pkt_mretflag;
    logic        r_pkt_ebreak;

    logic        r_out_valid;

    logic [2:0]  w_off;
    logic [2:0]  w_low_mask;
    logic [2:0]  w_eff_off;
    logic        w_misalign;
    logic        w_is_mem;
    logic        w_bad;
    logic        w_accept;
    logic        w_take_direct;
    logic        w_take_mem;
    logic        w_req_fire;
    logic        w_resp_take;
    logic [7:0]  w_lane_base;
    logic [7:0]  w_wmask;
    logic [63:0] w_wdata;
    logic [63:0] w_shifted;
    logic [63:0] w_load_data;
    logic [63:0] w_resp_lsures;

    assign w_off = io_EXLS_alures[2:0];

    // Per-size offset mask and store byte lanes
    always_comb begin
        w_low_mask  = 3'b000;
        w_lane_base = 8'h01;
        case (io_EXLS_func3[1:0])
            2'd0: begin w_low_mask = 3'b000; w_lane_base = 8'h01; end
            2'd1: begin w_low_mask = 3'b001; w_lane_base = 8'h03; end
            2'd2: begin w_low_mask = 3'b011; w_lane_base = 8'h0F; end
            default: begin w_low_mask = 3'b111; w_lane_base = 8'hFF; end
        endcase
    end

    // Aligned-down offset; identical to w_off whenever the access is aligned
    assign w_eff_off = w_off & ~w_low_mask;

`ifdef YSYX_22050550_LSU_MISALIGN_TRAP_EN
    assign w_misalign = |(w_off & w_low_mask);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_is_mem      = io_EXLS_readflag | io_EXLS_writeflag;
    assign w_bad         = w_is_mem & (w_misalign | (io_EXLS_func3 == 3'b111));
    assign io_EXLS_ready = !reset && (r_state == S_IDLE) && (!r_out_valid || io_ReadyWB_ready);
    assign w_accept      = io_EXLS_valid && io_EXLS_ready && !io_ls_flush;
    assign w_take_direct = w_accept && (!w_is_mem || w_bad);
    assign w_take_mem    = w_accept && w_is_mem && !w_bad;
    assign w_req_fire    = mem_req_valid && mem_req_ready;
    assign w_resp_take   = (r_state == S_WAIT) && mem_resp_valid && !io_ls_flush;

    assign w_wmask = io_EXLS_writeflag ? (w_lane_base << w_eff_off) : 8'h00;
    assign w_wdata = io_EXLS_writeflag ? (io_EXLS_rs2 << {w_eff_off, 3'b000}) : 64'd0;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a flush racing a request handshake still owes a response
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take_mem) w_state_next = S_REQ;
            end
            S_REQ: begin
                if (io_ls_flush)     w_state_next = w_req_fire ? S_DRAIN : S_IDLE;
                else if (w_req_fire) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid)   w_state_next = S_IDLE;
                else if (io_ls_flush) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (mem_resp_valid) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request channel register: fields stay stable until the handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= 64'd0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= 64'd0;
            mem_req_wmask <= 8'h00;
        end else if (w_take_mem) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {io_EXLS_alures[63:3], 3'b000};
            mem_req_wen   <= io_EXLS_writeflag;
            mem_req_wdata <= w_wdata;
            mem_req_wmask <= w_wmask;
        end else if ((r_state == S_REQ) && (w_req_fire || io_ls_flush)) begin
            mem_req_valid <= 1'b0;
        end
    end

    // Hold the memory packet while the request is outstanding
    always_ff @(posedge clock) begin
        if (w_take_mem) begin
            r_pkt_pc        <= io_EXLS_pc;
            r_pkt_inst      <= io_EXLS_inst;
            r_pkt_nextpc    <= io_EXLS_NextPc;
            r_pkt_alures    <= io_EXLS_alures;
            r_pkt_readflag  <= io_EXLS_readflag;
            r_pkt_writeflag <= io_EXLS_writeflag;
            r_pkt_func3     <= io_EXLS_func3;
            r_pkt_off       <= w_eff_off;
            r_pkt_waddr     <= io_EXLS_waddr;
            r_pkt_wen       <= io_EXLS_wen;
            r_pkt_csrflag   <= io_EXLS_csrflag;
            r_pkt_ecallflag <= io_EXLS_ecallflag;
            r_pkt_mretflag  <= io_EXLS_mretflag;
            r_pkt_ebreak    <= io_EXLS_ebreak;
        end
    end

    // Load data extraction and sign/zero extension
    always_comb begin
        w_shifted   = mem_resp_rdata >> {r_pkt_off, 3'b000};
        w_load_data = w_shifted;
        case (r_pkt_func3)
            3'b000:  w_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b100:  w_load_data = {56'd0,               w_shifted[7:0]};
            3'b001:  w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {48'd0,               w_shifted[15:0]};
            3'b010:  w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b110:  w_load_data = {32'd0,               w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
        w_resp_lsures = (r_pkt_writeflag || mem_resp_err) ? 64'd0 : w_load_data;
    end

    // Output register to WBU: flush clears, new packets load, WBU consumes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid       <= 1'b0;
            io_LSWB_pc        <= 64'd0;
            io_LSWB_inst      <= 32'd0;
            io_LSWB_NextPc    <= 64'd0;
            io_LSWB_alures    <= 64'd0;
            io_LSWB_lsures    <= 64'd0;
            io_LSWB_waddr     <= 5'd0;
            io_LSWB_wen       <= 1'b0;
            io_LSWB_func3     <= 3'd0;
            io_LSWB_readflag  <= 1'b0;
            io_LSWB_csrflag   <= 1'b0;
            io_LSWB_ecallflag <= 1'b0;
            io_LSWB_mretflag  <= 1'b0;
            io_LSWB_ebreak    <= 1'b0;
            io_LSWB_abort     <= 1'b0;
        end else if (io_ls_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_take_direct) begin
            r_out_valid       <= 1'b1;
            io_LSWB_pc        <= io_EXLS_pc;
            io_LSWB_inst      <= io_EXLS_inst;
            io_LSWB_NextPc    <= io_EXLS_NextPc;
            io_LSWB_alures    <= io_EXLS_alures;
            io_LSWB_lsures    <= 64'd0;
            io_LSWB_waddr     <= io_EXLS_waddr;
            io_LSWB_wen       <= io_EXLS_wen & ~w_bad;
            io_LSWB_func3     <= io_EXLS_func3;
            io_LSWB_readflag  <= io_EXLS_readflag;
            io_LSWB_csrflag   <= io_EXLS_csrflag;
            io_LSWB_ecallflag <= io_EXLS_ecallflag;
            io_LSWB_mretflag  <= io_EXLS_mretflag;
            io_LSWB_ebreak    <= io_EXLS_ebreak;
            io_LSWB_abort     <= w_bad;
        end else if (w_resp_take) begin
            r_out_valid       <= 1'b1;
            io_LSWB_pc        <= r_pkt_pc;
            io_LSWB_inst      <= r_pkt_inst;
            io_LSWB_NextPc    <= r_pkt_nextpc;
            io_LSWB_alures    <= r_pkt_alures;
            io_LSWB_lsures    <= w_resp_lsures;
            io_LSWB_waddr     <= r_pkt_waddr;
            io_LSWB_wen       <= r_pkt_wen & ~mem_resp_err;
            io_LSWB_func3     <= r_pkt_func3;
            io_LSWB_readflag  <= r_pkt_readflag;
            io_LSWB_csrflag   <= r_pkt_csrflag;
            io_LSWB_ecallflag <= r_pkt_ecallflag;
            io_LSWB_mretflag  <= r_pkt_mretflag;
            io_LSWB_ebreak    <= r_pkt_ebreak;
            io_LSWB_abort     <= mem_resp_err;
        end else if (io_ReadyWB_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_LSWB_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050550_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ysyx_22050550_lsu
// Purpose  : Directed self-checking bench for the load/store stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050550_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_EXLS_valid, io_EXLS_ready;
    logic [63:0] io_EXLS_pc, io_EXLS_NextPc, io_EXLS_alures, io_EXLS_rs2;
    logic [31:0] io_EXLS_inst;
    logic        io_EXLS_readflag, io_EXLS_writeflag;
    logic [2:0]  io_EXLS_func3;
    logic [4:0]  io_EXLS_waddr;
    logic        io_EXLS_wen, io_EXLS_csrflag, io_EXLS_ecallflag, io_EXLS_mretflag, io_EXLS_ebreak;
    logic        io_ls_flush;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid, mem_resp_err;
    logic [63:0] mem_resp_rdata;
    logic        io_LSWB_valid, io_ReadyWB_ready;
    logic [63:0] io_LSWB_pc, io_LSWB_NextPc, io_LSWB_alures, io_LSWB_lsures;
    logic [31:0] io_LSWB_inst;
    logic [4:0]  io_LSWB_waddr;
    logic        io_LSWB_wen, io_LSWB_readflag, io_LSWB_csrflag, io_LSWB_ecallflag;
    logic        io_LSWB_mretflag, io_LSWB_ebreak, io_LSWB_abort;
    logic [2:0]  io_LSWB_func3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ysyx_22050550_lsu dut (
        .clock(clock), .reset(reset),
        .io_EXLS_valid(io_EXLS_valid), .io_EXLS_ready(io_EXLS_ready),
        .io_EXLS_pc(io_EXLS_pc), .io_EXLS_inst(io_EXLS_inst), .io_EXLS_NextPc(io_EXLS_NextPc),
        .io_EXLS_alures(io_EXLS_alures), .io_EXLS_rs2(io_EXLS_rs2),
        .io_EXLS_readflag(io_EXLS_readflag), .io_EXLS_writeflag(io_EXLS_writeflag),
        .io_EXLS_func3(io_EXLS_func3), .io_EXLS_waddr(io_EXLS_waddr), .io_EXLS_wen(io_EXLS_wen),
        .io_EXLS_csrflag(io_EXLS_csrflag), .io_EXLS_ecallflag(io_EXLS_ecallflag),
        .io_EXLS_mretflag(io_EXLS_mretflag), .io_EXLS_ebreak(io_EXLS_ebreak),
        .io_ls_flush(io_ls_flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
        .io_LSWB_valid(io_LSWB_valid), .io_ReadyWB_ready(io_ReadyWB_ready),
        .io_LSWB_pc(io_LSWB_pc), .io_LSWB_inst(io_LSWB_inst), .io_LSWB_NextPc(io_LSWB_NextPc),
        .io_LSWB_alures(io_LSWB_alures), .io_LSWB_lsures(io_LSWB_lsures),
        .io_LSWB_waddr(io_LSWB_waddr), .io_LSWB_wen(io_LSWB_wen), .io_LSWB_func3(io_LSWB_func3),
        .io_LSWB_readflag(io_LSWB_readflag), .io_LSWB_csrflag(io_LSWB_csrflag),
        .io_LSWB_ecallflag(io_LSWB_ecallflag), .io_LSWB_mretflag(io_LSWB_mretflag),
        .io_LSWB_ebreak(io_LSWB_ebreak), .io_LSWB_abort(io_LSWB_abort)
    );

    // Load vectors: func3, address, memory word, expected request address, expected lsures
    localparam logic [2:0]  LD_F3   [7] = '{3'b000, 3'b100, 3'b001, 3'b110, 3'b010, 3'b011, 3'b101};
    localparam logic [63:0] LD_ADDR [7] = '{64'h80000003, 64'h80000003, 64'h80000006, 64'h80000004,
                                            64'h80000004, 64'h80000008, 64'h8000001A};
    localparam logic [63:0] LD_RD   [7] = '{64'h0000000080000000, 64'h0000000080000000,
                                            64'h8123000000000000, 64'hDEADBEEF00000000,
                                            64'hDEADBEEF00000000, 64'h0123456789ABCDEF,
                                            64'h00000000F00D0000};
    localparam logic [63:0] LD_REQ  [7] = '{64'h80000000, 64'h80000000, 64'h80000000, 64'h80000000,
                                            64'h80000000, 64'h80000008, 64'h80000018};
    localparam logic [63:0] LD_EXP  [7] = '{64'hFFFFFFFFFFFFFF80, 64'h0000000000000080,
                                            64'hFFFFFFFFFFFF8123, 64'h00000000DEADBEEF,
                                            64'hFFFFFFFFDEADBEEF, 64'h0123456789ABCDEF,
                                            64'h000000000000F00D};

    // Store vectors: func3, address, rs2, expected mask, expected wdata
    localparam logic [2:0]  ST_F3   [3] = '{3'b001, 3'b000, 3'b010};
    localparam logic [63:0] ST_ADDR [3] = '{64'h80000006, 64'h80000005, 64'h80000004};
    localparam logic [63:0] ST_RS2  [3] = '{64'h000000000000BEEF, 64'hFFFFFFFFFFFFFF12, 64'h00000000CAFEF00D};
    localparam logic [7:0]  ST_MASK [3] = '{8'hC0, 8'h20, 8'hF0};
    localparam logic [63:0] ST_WD   [3] = '{64'hBEEF000000000000, 64'hFFFF120000000000, 64'hCAFEF00D00000000};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        io_EXLS_valid = 0; io_EXLS_pc = 64'h80001000; io_EXLS_inst = 32'h00000013;
        io_EXLS_NextPc = 64'h80001004; io_EXLS_alures = 0; io_EXLS_rs2 = 0;
        io_EXLS_readflag = 0; io_EXLS_writeflag = 0; io_EXLS_func3 = 0; io_EXLS_waddr = 0;
        io_EXLS_wen = 0; io_EXLS_csrflag = 0; io_EXLS_ecallflag = 0; io_EXLS_mretflag = 0;
        io_EXLS_ebreak = 0; io_ls_flush = 0; mem_req_ready = 0; mem_resp_valid = 0;
        mem_resp_rdata = 0; mem_resp_err = 0; io_ReadyWB_ready = 1;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        tick(); tick();
        checks++; if (io_LSWB_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", io_LSWB_valid); end
        checks++; if (io_LSWB_alures !== 64'd0) begin errors++; $display("FAIL rst_alures: got %h want 0", io_LSWB_alures); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (mem_req_addr !== 64'd0 || mem_req_wmask !== 8'd0 || mem_req_wdata !== 64'd0)
            begin errors++; $display("FAIL rst_req_fields: got %h/%h/%h want 0", mem_req_addr, mem_req_wmask, mem_req_wdata); end
        checks++; if (io_EXLS_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %b want 0", io_EXLS_ready); end
        reset = 0;
        #1;
        checks++; if (io_EXLS_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", io_EXLS_ready); end
    endtask

    task automatic test_back_to_back();
        io_EXLS_valid = 1; io_EXLS_alures = 64'h1234; io_EXLS_wen = 1; io_EXLS_waddr = 5'd3;
        tick();
        checks++; if (io_LSWB_valid !== 1'b1 || io_LSWB_alures !== 64'h1234)
            begin errors++; $display("FAIL b2b_first: got v=%b alures=%h want v=1 alures=1234", io_LSWB_valid, io_LSWB_alures); end
        checks++; if (io_LSWB_wen !== 1'b1 || io_LSWB_abort !== 1'b0 || io_LSWB_waddr !== 5'd3)
            begin errors++; $display("FAIL b2b_first_ctl: got wen=%b abort=%b waddr=%0d want 1/0/3", io_LSWB_wen, io_LSWB_abort, io_LSWB_waddr); end
        checks++; if (io_EXLS_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", io_EXLS_ready); end
        io_EXLS_alures = 64'h5678;
        tick();
        checks++; if (io_LSWB_valid !== 1'b1 || io_LSWB_alures !== 64'h5678)
            begin errors++; $display("FAIL b2b_second: got v=%b alures=%h want v=1 alures=5678", io_LSWB_valid, io_LSWB_alures); end
        io_EXLS_valid = 0; io_EXLS_wen = 0;
        tick();
        checks++; if (io_LSWB_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", io_LSWB_valid); end
    endtask

    task automatic test_loads();
        for (int i = 0; i < 7; i++) begin
            io_EXLS_valid = 1; io_EXLS_readflag = 1; io_EXLS_func3 = LD_F3[i];
            io_EXLS_alures = LD_ADDR[i]; io_EXLS_wen = 1; io_EXLS_waddr = 5'(i + 1);
            mem_req_ready = 1;
            tick();
            io_EXLS_valid = 0; io_EXLS_readflag = 0; io_EXLS_wen = 0;
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== LD_REQ[i] || mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00)
                begin errors++; $display("FAIL ld%0d_req: got v=%b addr=%h wen=%b mask=%h want 1/%h/0/00", i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, LD_REQ[i]); end
            tick();
            checks++; if (mem_req_valid !== 1'b0 || io_LSWB_valid !== 1'b0)
                begin errors++; $display("FAIL ld%0d_wait: got req=%b out=%b want 0/0", i, mem_req_valid, io_LSWB_valid); end
            mem_resp_valid = 1; mem_resp_rdata = LD_RD[i];
            tick();
            mem_resp_valid = 0;
            checks++; if (io_LSWB_valid !== 1'b1 || io_LSWB_lsures !== LD_EXP[i])
                begin errors++; $display("FAIL ld%0d_data: got v=%b lsures=%h want 1/%h", i, io_LSWB_valid, io_LSWB_lsures, LD_EXP[i]); end
            checks++; if (io_LSWB_wen !== 1'b1 || io_LSWB_abort !== 1'b0 || io_LSWB_waddr !== 5'(i + 1))
                begin errors++; $display("FAIL ld%0d_ctl: got wen=%b abort=%b waddr=%0d want 1/0/%0d", i, io_LSWB_wen, io_LSWB_abort, io_LSWB_waddr, i + 1); end
            tick();
        end
        mem_req_ready = 0;
    endtask

    task automatic test_stores();
        for (int i = 0; i < 3; i++) begin
            io_EXLS_valid = 1; io_EXLS_writeflag = 1; io_EXLS_func3 = ST_F3[i];
            io_EXLS_alures = ST_ADDR[i]; io_EXLS_rs2 = ST_RS2[i]; mem_req_ready = 0;
            tick();
            io_EXLS_valid = 0; io_EXLS_writeflag = 0;
            for (int j = 0; j < 3; j++) begin
                checks++; if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1 || mem_req_addr !== 64'h80000000 ||
                              mem_req_wmask !== ST_MASK[i] || mem_req_wdata !== ST_WD[i])
                    begin errors++; $display("FAIL st%0d_req_c%0d: got v=%b wen=%b addr=%h mask=%h wd=%h want 1/1/80000000/%h/%h",
                                             i, j, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wmask, mem_req_wdata, ST_MASK[i], ST_WD[i]); end
                tick();
            end
            mem_req_ready = 1;
            tick();
            mem_req_ready = 0;
            checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL st%0d_req_drop: got %b want 0", i, mem_req_valid); end
            mem_resp_valid = 1; mem_resp_rdata = 64'hFFFFFFFFFFFFFFFF;
            tick();
            mem_resp_valid = 0;
            checks++; if (io_LSWB_valid !== 1'b1 || io_LSWB_lsures !== 64'd0 || io_LSWB_wen !== 1'b0 || io_LSWB_abort !== 1'b0)
                begin errors++; $display("FAIL st%0d_out: got v=%b lsures=%h wen=%b abort=%b want 1/0/0/0", i, io_LSWB_valid, io_LSWB_lsures, io_LSWB_wen, io_LSWB_abort); end
            tick();
        end
    endtask

    task automatic test_misalign();
        io_EXLS_valid = 1; io_EXLS_readflag = 1; io_EXLS_func3 = 3'b010;
        io_EXLS_alures = 64'h80000002; io_EXLS_wen = 1; io_EXLS_waddr = 5'd11; mem_req_ready = 1;
        tick();
        io_EXLS_valid = 0; io_EXLS_readflag = 0; io_EXLS_wen = 0;
`ifdef YSYX_22050550_LSU_MISALIGN_TRAP_EN
        checks++; if (io_LSWB_valid !== 1'b1 || io_LSWB_abort !== 1'b1 || io_LSWB_wen !== 1'b0 || mem_req_valid !== 1'b0)
            begin errors++; $display("FAIL mis_abort: got v=%b abort=%b wen=%b req=%b want 1/1/0/0", io_LSWB_valid, io_LSWB_abort, io_LSWB_wen, mem_req_valid); end
        tick();
`else
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h80000000 || io_LSWB_valid !== 1'b0)
            begin errors++; $display("FAIL mis_req: got req=%b addr=%h out=%b want 1/80000000/0", mem_req_valid, mem_req_addr, io_LSWB_valid); end
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h1122334455667788;
        tick();
        mem_resp_valid = 0;
        checks++; if (io_LSWB_valid !== 1'b1 || io_LSWB_lsures !== 64'h0000000055667788 || io_LSWB_abort !== 1'b0)
            begin errors++; $display("FAIL mis_data: got v=%b lsures=%h abort=%b want 1/55667788/0", io_LSWB_valid, io_LSWB_lsures, io_LSWB_abort); end
        tick();
`endif
        mem_req_ready = 0;
    endtask

    task automatic test_flush_req();
        int hs;
        hs = 0;
        io_EXLS_valid = 1; io_EXLS_writeflag = 1; io_EXLS_func3 = 3'b011;
        io_EXLS_alures = 64'h80000010; io_EXLS_rs2 = 64'h1111; mem_req_ready = 0;
        tick();
        io_EXLS_valid = 0; io_EXLS_writeflag = 0;
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL flreq_pre: got %b want 1", mem_req_valid); end
        io_ls_flush = 1;
        tick();
        io_ls_flush = 0;
        checks++; if (mem_req_valid !== 1'b0 || io_EXLS_ready !== 1'b1 || io_LSWB_valid !== 1'b0)
            begin errors++; $display("FAIL flreq_post: got req=%b rdy=%b out=%b want 0/1/0", mem_req_valid, io_EXLS_ready, io_LSWB_valid); end
        mem_req_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (mem_req_valid && mem_req_ready) hs++;
            tick();
        end
        mem_req_ready = 0;
        checks++; if (hs !== 0) begin errors++; $display("FAIL flreq_handshakes: got %0d want 0", hs); end
    endtask

    task automatic test_flush_wait();
        io_EXLS_valid = 1; io_EXLS_readflag = 1; io_EXLS_func3 = 3'b011;
        io_EXLS_alures = 64'h80000040; io_EXLS_wen = 1; mem_req_ready = 1;
        tick();
        io_EXLS_valid = 0; io_EXLS_readflag = 0;
        tick();
        mem_req_ready = 0; io_ls_flush = 1;
        tick();
        io_ls_flush = 0;
        io_EXLS_valid = 1; io_EXLS_alures = 64'hAAAA; io_EXLS_waddr = 5'd9;
        #1;
        checks++; if (io_EXLS_ready !== 1'b0) begin errors++; $display("FAIL flwait_drain_ready: got %b want 0", io_EXLS_ready); end
        tick();
        checks++; if (io_LSWB_valid !== 1'b0 || io_EXLS_ready !== 1'b0)
            begin errors++; $display("FAIL flwait_hold: got out=%b rdy=%b want 0/0", io_LSWB_valid, io_EXLS_ready); end
        mem_resp_valid = 1; mem_resp_rdata = 64'h5555;
        tick();
        mem_resp_valid = 0;
        checks++; if (io_LSWB_valid !== 1'b0 || io_EXLS_ready !== 1'b1)
            begin errors++; $display("FAIL flwait_discard: got out=%b rdy=%b want 0/1", io_LSWB_valid, io_EXLS_ready); end
        tick();
        io_EXLS_valid = 0; io_EXLS_wen = 0;
        checks++; if (io_LSWB_valid !== 1'b1 || io_LSWB_alures !== 64'hAAAA)
            begin errors++; $display("FAIL flwait_next: got v=%b alures=%h want 1/aaaa", io_LSWB_valid, io_LSWB_alures); end
        tick();
    endtask

    task automatic test_flush_accept();
        io_EXLS_valid = 1; io_EXLS_alures = 64'hBBBB; io_EXLS_wen = 1; io_ls_flush = 1;
        tick();
        io_EXLS_valid = 0; io_EXLS_wen = 0; io_ls_flush = 0;
        checks++; if (io_LSWB_valid !== 1'b0) begin errors++; $display("FAIL flacc_drop: got %b want 0", io_LSWB_valid); end
    endtask

    task automatic test_err_hold_reset();
        io_EXLS_valid = 1; io_EXLS_readflag = 1; io_EXLS_func3 = 3'b011;
        io_EXLS_alures = 64'h80000020; io_EXLS_wen = 1; io_EXLS_waddr = 5'd5; mem_req_ready = 1;
        tick();
        io_EXLS_valid = 0; io_EXLS_readflag = 0; io_EXLS_wen = 0;
        tick();
        mem_req_ready = 0; io_ReadyWB_ready = 0; mem_resp_valid = 1; mem_resp_err = 1;
        mem_resp_rdata = 64'h0123;
        tick();
        mem_resp_valid = 0; mem_resp_err = 0;
        checks++; if (io_LSWB_valid !== 1'b1 || io_LSWB_abort !== 1'b1 || io_LSWB_wen !== 1'b0 || io_LSWB_waddr !== 5'd5)
            begin errors++; $display("FAIL err_out: got v=%b abort=%b wen=%b waddr=%0d want 1/1/0/5", io_LSWB_valid, io_LSWB_abort, io_LSWB_wen, io_LSWB_waddr); end
        tick();
        checks++; if (io_LSWB_valid !== 1'b1 || io_LSWB_abort !== 1'b1 || io_LSWB_alures !== 64'h80000020 || io_EXLS_ready !== 1'b0)
            begin errors++; $display("FAIL err_hold: got v=%b abort=%b alures=%h rdy=%b want 1/1/80000020/0", io_LSWB_valid, io_LSWB_abort, io_LSWB_alures, io_EXLS_ready); end
        io_ReadyWB_ready = 1;
        tick();
        checks++; if (io_LSWB_valid !== 1'b0) begin errors++; $display("FAIL err_consumed: got %b want 0", io_LSWB_valid); end
        io_EXLS_valid = 1; io_EXLS_readflag = 1; io_EXLS_alures = 64'h80000028; mem_req_ready = 1;
        tick();
        io_EXLS_valid = 0; io_EXLS_readflag = 0;
        tick();
        mem_req_ready = 0; reset = 1;
        tick();
        checks++; if (io_LSWB_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 64'd0 || io_EXLS_ready !== 1'b0)
            begin errors++; $display("FAIL midwait_reset: got out=%b req=%b addr=%h rdy=%b want 0/0/0/0", io_LSWB_valid, mem_req_valid, mem_req_addr, io_EXLS_ready); end
        reset = 0;
        #1;
        checks++; if (io_EXLS_ready !== 1'b1) begin errors++; $display("FAIL midwait_ready: got %b want 1", io_EXLS_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_loads();
        test_stores();
        test_misalign();
        test_flush_req();
        test_flush_wait();
        test_flush_accept();
        test_err_hold_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22050550_lsu.md
# ysyx_22050550_lsu

Load/store stage of the ysyx_22050550 pipeline, between the execute stage (EXU) and the write-back unit (WBU). It accepts one EXU packet at a time and issues at most one data-memory request per packet over a valid/ready request channel. It formats load data, registers the packet and forwards it to WBU on the io_LSWB_* bundle. Misaligned or faulted accesses are turned into aborted packets, and in-flight work is discarded on a pipeline flush.

## Interface
Parameters
- none; the data width is fixed at 64 bits and the register index at 5 bits.

Ports
- clock  in  1  stage clock
- reset  in  1  synchronous, active-high
- io_EXLS_valid / io_EXLS_ready  in/out  1  EXU packet handshake
- io_EXLS_pc  in  64; io_EXLS_inst  in  32; io_EXLS_NextPc  in  64  passed through
- io_EXLS_alures  in  64  effective address (memory op) or ALU result
- io_EXLS_rs2  in  64  store data
- io_EXLS_readflag, io_EXLS_writeflag  in  1  load / store
- io_EXLS_func3  in  3  access size and sign
- io_EXLS_waddr  in  5; io_EXLS_wen  in  1  destination register
- io_EXLS_csrflag, io_EXLS_ecallflag, io_EXLS_mretflag, io_EXLS_ebreak  in  1  passed through
- io_ls_flush  in  1  kill in-flight packet (driven from WBU iruflush/irujump)
- mem_req_valid  out  1; mem_req_ready  in  1
- mem_req_addr  out  64  8-byte aligned address (low 3 bits zero)
- mem_req_wen  out  1  store request
- mem_req_wdata  out  64; mem_req_wmask  out  8  byte-lane data and mask
- mem_resp_valid  in  1; mem_resp_rdata  in  64; mem_resp_err  in  1
- io_LSWB_valid  out  1; io_ReadyWB_ready  in  1  WBU handshake
- io_LSWB_pc, _inst, _NextPc, _alures, _lsures, _waddr, _wen, _func3, _readflag, _csrflag, _ecallflag, _mretflag, _ebreak, _abort  out  registered packet to WBU

## Operation
- State machine:
  - IDLE, REQ, WAIT and DRAIN handle the memory side.
  - The output register is held, with io_LSWB_valid=1, until io_ReadyWB_ready.
- io_EXLS_ready:
  - It is 1 in IDLE when the output register is empty or is being consumed this cycle.
  - It is 0 in all other states and while reset is high.
- Accepting a packet whose readflag and writeflag are both 0:
  - The packet loads straight into the output register; state stays IDLE.
- Accepting a memory op:
  - The packet is latched. State goes to REQ, or to IDLE with an aborted output if the access is misaligned.
- Address and byte offset: off = alures[2:0]; mem_req_addr = {alures[63:3],3'b0}.
- Store lanes: sb 8'h01<<off, sh 8'h03<<off, sw 8'h0F<<off, sd 8'hFF. mem_req_wdata = rs2 << (8*off).
- REQ:
  - mem_req_valid is held high with stable fields until mem_req_ready, then the state moves to WAIT.
  - Loads drive wmask=0.
- WAIT: on mem_resp_valid, the packet enters the output register and the state returns to IDLE.
- Load formatting: data = rdata >> (8*off). Then:
  - func3 000 lb and 100 lbu: sign- / zero-extend byte.
  - 001 lh and 101 lhu: sign- / zero-extend half.
  - 010 lw and 110 lwu: sign- / zero-extend word.
  - 011 ld: full 64 bits.
  - func3 111 is treated as an abort.
- Stores: lsures=0 and the response data is ignored.
- Abort (misalign, mem_resp_err, or illegal func3):
  - io_LSWB_abort=1 and io_LSWB_wen=0; other fields pass through.
- Non-aborted packets: io_LSWB_wen = io_EXLS_wen.
- Flush:
  - IDLE: the output register is cleared (valid=0).
  - REQ: the request is withdrawn next cycle and the state returns to IDLE, so no store is performed.
  - WAIT: the state goes to DRAIN, which waits for mem_resp_valid, discards it, then returns to IDLE.
  - Flush overrides a simultaneous acceptance: the accepting packet is dropped.

## Timing
- Reset (synchronous):
  - State IDLE.
  - All io_LSWB_* outputs, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata and mem_req_wmask are 0.
- Non-memory packet: accepted in cycle N, io_LSWB_valid=1 in N+1.
- Memory packet accepted in cycle N:
  - mem_req_valid=1 from N+1.
  - The response is legal no earlier than the cycle after the request handshake.
  - io_LSWB_valid=1 in the cycle after mem_resp_valid.
  - Minimum load latency with zero-wait memory: 3 cycles.
- Misaligned packet: accepted in N, aborted output in N+1, no memory request.
- Throughput:
  - One non-memory packet per cycle when WBU is always ready.
  - One memory packet per round-trip plus 1 cycle.
- Output held: while io_LSWB_valid=1 and io_ReadyWB_ready=0, every io_LSWB_* field is stable.

## Configuration
- YSYX_22050550_LSU_MISALIGN_TRAP_EN defined:
  - An access with off not a multiple of its size (half: off[0]; word: off[1:0]; double: off[2:0]) is aborted without a memory request.
- Macro undefined:
  - No check is made; off is aligned down to the access size (e.g. lh at off=3 uses off=2) and the request proceeds.

## Test plan
- Zero-wait back-to-back ALU packets, alures=0x1234 then 0x5678 with wen=1 -> io_LSWB_valid on consecutive cycles with matching alures; lsures unused.
- lb at 0x80000003, rdata=0x00000000_80000000 -> lsures=0xFFFFFFFFFFFFFF80; the lbu variant gives 0x80.
- sh at 0x80000006, rs2=0xBEEF -> mem_req_wmask=8'hC0, mem_req_wdata=0xBEEF000000000000, mem_req_wen=1; mem_req_ready withheld 3 cycles keeps the request stable.
- lw at 0x80000002:
  - Macro on -> abort=1, wen=0, no mem_req_valid.
  - Macro off -> request to 0x80000000 with word lanes 0-3.
- io_ls_flush:
  - Asserted in REQ for a store -> no write handshake.
  - Asserted in WAIT -> response discarded, io_LSWB_valid stays 0, next packet accepted only after the response.
- mem_resp_err=1 on an ld with wen=1, waddr=5 -> io_LSWB_abort=1, io_LSWB_wen=0; reset asserted mid-WAIT -> all outputs 0 next cycle, io_EXLS_ready=1 the cycle after reset drops.
